// File: rtl/ramb4_pkg.sv
// Shared constants and types for the 512x8 true dual-port block RAM.
`timescale 1ns/1ps
package ramb4_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage : ramb4_pkg

// File: rtl/ramb4_port.sv
// One RAM port: enable gating, write-first selection and the async-reset
// output register. The read data arriving here is already collision-resolved.
`timescale 1ns/1ps
module ramb4_port
  import ramb4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] dout
);

  data_t dout_q;
  data_t dout_d;

  // Next output: hold when disabled, own write data when writing, else array data
  always_comb begin
    dout_d = dout_q;
    if (en) begin
      dout_d = we ? din : rdata;
    end
  end

  // Output register, cleared asynchronously and held clear during reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule : ramb4_port

// File: rtl/ramb4_s8_s8.sv
// 512x8 true dual-port synchronous RAM, common clock, write-first per port.
// Build option: define RAMB4_COLLISION_BYPASS_EN to forward the writing
// port's din to the other port on a same-address read/write collision;
// otherwise the reading port sees the array contents from before the write.
`timescale 1ns/1ps
module ramb4_s8_s8
  import ramb4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  input  logic              en_a,
  input  logic              we_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  input  logic              en_b,
  input  logic              we_b,
  output logic [DATA_W-1:0] dout_b
);

  data_t mem_q [DEPTH];
  data_t rdata_a_c;
  data_t rdata_b_c;

  // Shared array; port B is written last so it wins a same-address dual write
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (en_a && we_a) begin
        mem_q[addr_a] <= din_a;
      end
      if (en_b && we_b) begin
        mem_q[addr_b] <= din_b;
      end
    end
  end

  // Array read data per port, with optional cross-port write forwarding
  always_comb begin
    rdata_a_c = mem_q[addr_a];
    rdata_b_c = mem_q[addr_b];
`ifdef RAMB4_COLLISION_BYPASS_EN
    if (en_b && we_b && (addr_a == addr_b)) begin
      rdata_a_c = din_b;
    end
    if (en_a && we_a && (addr_a == addr_b)) begin
      rdata_b_c = din_a;
    end
`endif
  end

  ramb4_port u_port_a (
    .clk   (clk),
    .rst   (rst),
    .en    (en_a),
    .we    (we_a),
    .din   (din_a),
    .rdata (rdata_a_c),
    .dout  (dout_a)
  );

  ramb4_port u_port_b (
    .clk   (clk),
    .rst   (rst),
    .en    (en_b),
    .we    (we_b),
    .din   (din_b),
    .rdata (rdata_b_c),
    .dout  (dout_b)
  );

endmodule : ramb4_s8_s8

// File: tb/tb_ramb4_s8_s8.sv
// Directed scoreboard bench for ramb4_s8_s8 (both collision build options).
`timescale 1ns/1ps
module tb_ramb4_s8_s8;

`ifdef RAMB4_COLLISION_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] addr_a = '0, addr_b = '0;
  logic [7:0] din_a = '0, din_b = '0;
  logic       en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [7:0] dout_a, dout_b;

  ramb4_s8_s8 dut (
    .clk    (clk),
    .rst    (rst),
    .addr_a (addr_a),
    .din_a  (din_a),
    .en_a   (en_a),
    .we_a   (we_a),
    .dout_a (dout_a),
    .addr_b (addr_b),
    .din_b  (din_b),
    .en_b   (en_b),
    .we_b   (we_b),
    .dout_b (dout_b)
  );

  always #5 clk = ~clk;

  // Reference state: array contents and both output registers
  logic [7:0] mmem [512];
  logic [7:0] mdout_a = '0;
  logic [7:0] mdout_b = '0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: predict, push, drive, then pop and compare after the edge
  task automatic apply(input string tag,
                       input logic ena, input logic wea, input logic [8:0] aa, input logic [7:0] da,
                       input logic enb, input logic web, input logic [8:0] ab, input logic [7:0] db);
    exp_t e;
    exp_t got;
    string t;
    logic coll;
    e.a = mdout_a;
    e.b = mdout_b;
    coll = (aa == ab);
    if (ena) begin
      if (wea)                             e.a = da;
      else if (enb && web && coll && BYPASS) e.a = db;
      else                                 e.a = mmem[aa];
    end
    if (enb) begin
      if (web)                             e.b = db;
      else if (ena && wea && coll && BYPASS) e.b = da;
      else                                 e.b = mmem[ab];
    end
    if (ena && wea) mmem[aa] = da;
    if (enb && web) mmem[ab] = db;
    mdout_a = e.a;
    mdout_b = e.b;
    sb_q.push_back(e);
    tag_q.push_back(tag);

    en_a = ena; we_a = wea; addr_a = aa; din_a = da;
    en_b = enb; we_b = web; addr_b = ab; din_b = db;
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    t   = tag_q.pop_front();
    check({t, "/dout_a"}, dout_a, got.a);
    check({t, "/dout_b"}, dout_b, got.b);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check("por/dout_a", dout_a, 8'h00);
    check("por/dout_b", dout_b, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Preload known contents
    apply("setup0", 1, 1, 9'h005, 8'h3C, 1, 1, 9'h020, 8'h11);
    apply("setup1", 1, 1, 9'h010, 8'h44, 1, 1, 9'h040, 8'h66);

    // Mid-operation async reset with writes attempted while held
    en_a = 1; we_a = 0; addr_a = 9'h005; en_b = 1; we_b = 0; addr_b = 9'h010;
    #2 rst = 1'b1;
    #1;
    check("async_rst/dout_a", dout_a, 8'h00);
    check("async_rst/dout_b", dout_b, 8'h00);
    mdout_a = '0;
    mdout_b = '0;
    we_a = 1; din_a = 8'hEE; we_b = 1; addr_b = 9'h020; din_b = 8'hEE;
    @(posedge clk);
    #1;
    check("rst_hold/dout_a", dout_a, 8'h00);
    check("rst_hold/dout_b", dout_b, 8'h00);
    @(negedge clk);
    en_a = 0; we_a = 0; en_b = 0; we_b = 0;
    rst = 1'b0;
    apply("post_rst_rd", 1, 0, 9'h005, 8'h00, 1, 0, 9'h020, 8'h00);
    check("post_rst_rd/const_a", dout_a, 8'h3C);
    check("post_rst_rd/const_b", dout_b, 8'h11);

    // Basic write-first on B, readback on A
    apply("basic_wr", 0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'hA5);
    check("basic_wr/const_b", dout_b, 8'hA5);
    apply("basic_rd", 1, 0, 9'h1FF, 8'h00, 0, 0, 9'h000, 8'h00);
    check("basic_rd/const_a", dout_a, 8'hA5);

    // Disabled port with we high: no write, output holds
    apply("en_off", 0, 1, 9'h010, 8'h77, 0, 0, 9'h000, 8'h00);
    check("en_off/hold_a", dout_a, 8'hA5);
    apply("en_off_rd", 1, 0, 9'h010, 8'h00, 0, 0, 9'h000, 8'h00);
    check("en_off_rd/const_a", dout_a, 8'h44);

    // Cross-port collisions in both directions
    apply("coll_ba", 1, 0, 9'h020, 8'h00, 1, 1, 9'h020, 8'h5A);
    check("coll_ba/const_a", dout_a, BYPASS ? 8'h5A : 8'h11);
    apply("coll_ba_rd", 1, 0, 9'h020, 8'h00, 0, 0, 9'h000, 8'h00);
    check("coll_ba_rd/const_a", dout_a, 8'h5A);
    apply("coll_ab", 1, 1, 9'h040, 8'h99, 1, 0, 9'h040, 8'h00);
    check("coll_ab/const_b", dout_b, BYPASS ? 8'h99 : 8'h66);

    // Dual write to one address: B wins the array, each port sees its own din
    apply("dual_wr", 1, 1, 9'h030, 8'h01, 1, 1, 9'h030, 8'h02);
    check("dual_wr/const_a", dout_a, 8'h01);
    check("dual_wr/const_b", dout_b, 8'h02);
    apply("dual_rd", 1, 0, 9'h030, 8'h00, 1, 0, 9'h030, 8'h00);
    check("dual_rd/const_a", dout_a, 8'h02);

    // Independent traffic sweep: A writes i, B reads i-1
    for (int i = 0; i < 512; i++) begin
      apply("sweep", 1, 1, 9'(i), 8'(i) ^ 8'h55, 1, 0, 9'(i - 1), 8'h00);
      if (i > 0) check("sweep/formula_b", dout_b, 8'(i - 1) ^ 8'h55);
    end

    en_a = 0; we_a = 0; en_b = 0; we_b = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ramb4_s8_s8
